// File: rtl/ram_wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the four RAM chip backdoors.
// The arbiter uses the slave modport; the environment (masters and chips) uses the master modport.
interface ram_wb_arbiter_if;
  logic         m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0]  m0_addr_i, m0_data_i, m0_data_o;
  logic         m0_ack_o, m0_err_o;
  logic         m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0]  m1_addr_i, m1_data_i, m1_data_o;
  logic         m1_ack_o, m1_err_o;
  logic [3:0]   s_cyc_o, s_stb_o;
  logic         s_we_o;
  logic [31:0]  s_addr_o, s_data_o;
  logic [127:0] s_data_i;
  logic [3:0]   s_ack_i;

  // Arbiter side
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  // Masters and chips side
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i
  );
endinterface

// File: rtl/ram_wb_arbiter.sv
// Round-robin arbiter sharing the Wishbone backdoor of four RAM chips between two masters.
module ram_wb_arbiter #(
  parameter int unsigned TIMEOUT   = 31,
  parameter int unsigned NUM_CHIPS = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  ram_wb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DATA_W = 32;

  if (NUM_CHIPS != 4) begin : g_bad_num_chips
    $error("ram_wb_arbiter: NUM_CHIPS must be 4");
  end
  if (TIMEOUT < 9 || TIMEOUT > 63) begin : g_bad_timeout
    $error("ram_wb_arbiter: TIMEOUT must be in 9..63");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   gnt_q, gnt_d;
  logic [1:0]             chip_q, chip_d;
  logic                   abort_q, abort_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             s_cyc_q, s_cyc_d;
  logic                   s_we_q, s_we_d;
  logic [DATA_W-1:0]      s_addr_q, s_addr_d;
  logic [DATA_W-1:0]      s_data_q, s_data_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]             ack_q, ack_d;
  logic [1:0]             err_q, err_d;

  logic              req0, req1, pick;
  logic [31:0]       sel_addr;
  logic [3:0]        sel_wdata;
  logic              sel_we;
  logic              gnt_cyc, ack_hit, aborting;
  logic [DATA_W-1:0] chip_rdata;

  // Request decode and round-robin pick: on a tie the master that did not win last time goes
  assign req0      = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1      = bus.m1_cyc_i & bus.m1_stb_i;
  assign pick      = (req0 & req1) ? ~last_q : req1;
  assign sel_addr  = pick ? bus.m1_addr_i : bus.m0_addr_i;
  assign sel_wdata = pick ? bus.m1_data_i[3:0] : bus.m0_data_i[3:0];
  assign sel_we    = pick ? bus.m1_we_i : bus.m0_we_i;

  // Granted-chip view while waiting; a master dropping cyc only suppresses its own response
  assign gnt_cyc    = gnt_q ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign aborting   = abort_q | ~gnt_cyc;
  assign ack_hit    = bus.s_ack_i[chip_q];
  assign chip_rdata = bus.s_data_i[{chip_q, 5'd0} +: DATA_W];

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    chip_d   = chip_q;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    s_cyc_d  = s_cyc_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
    err_d    = '0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          last_d  = pick;
          chip_d  = sel_addr[10:9];
          abort_d = 1'b0;
          cnt_d   = '0;
          if (sel_addr[31:11] != 21'd0) begin
            state_d = ERR;
          end else begin
            state_d  = WAIT;
            s_cyc_d  = 4'(1) << sel_addr[10:9];
            s_we_d   = sel_we;
            s_addr_d = {23'd0, sel_addr[8:2], 2'b00};
            s_data_d = {28'd0, sel_wdata};
          end
        end
      end
      WAIT: begin
        abort_d = aborting;
        if (ack_hit) begin
          // Drop the strobe on the ack edge so a halted chip is not re-triggered
          s_cyc_d = '0;
          state_d = RESP;
          if (!s_we_q && !aborting) begin
            rdata_d[gnt_q] = chip_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          s_cyc_d = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (!abort_q) ack_d[gnt_q] = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        if (!abort_q) err_d[gnt_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      chip_q   <= '0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
      s_cyc_q  <= '0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      chip_q   <= chip_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
      s_cyc_q  <= s_cyc_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.s_cyc_o   = s_cyc_q;
  assign bus.s_stb_o   = s_cyc_q;
  assign bus.s_we_o    = s_we_q;
  assign bus.s_addr_o  = s_addr_q;
  assign bus.s_data_o  = s_data_q;
  assign bus.m0_data_o = rdata_q[0];
  assign bus.m1_data_o = rdata_q[1];
  assign bus.m0_ack_o  = ack_q[0];
  assign bus.m1_ack_o  = ack_q[1];
  assign bus.m0_err_o  = err_q[0];
  assign bus.m1_err_o  = err_q[1];

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Self-checking bench for ram_wb_arbiter: directed vector table, hand-written corner sequences
// and randomized rounds checked against a transaction-level model of the arbiter.
module tb_ram_wb_arbiter;

  localparam int TIMEOUT = 31;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_wb_arbiter_if bus();

  ram_wb_arbiter #(.TIMEOUT(TIMEOUT), .NUM_CHIPS(4)) u_dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wd;
    int          d;
    logic [3:0]  rn;
    logic [3:0]  ecyc;
    logic [31:0] esaddr;
    bit          eerr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_data [2];
  int          last_gnt;
  logic [31:0] ta [2];
  logic        twe [2];
  logic [3:0]  twd [2];
  int          td [2];
  logic [3:0]  tn [2];
  vec_t        vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Model: chip strobe pattern for an address, zero for a decode error
  function automatic logic [3:0] cyc_of(input logic [31:0] a);
    if (a >= 32'h800) return 4'd0;
    return 4'(1 << ((a >> 9) % 4));
  endfunction

  task automatic set_req(input int m, input logic we, input logic [31:0] a, input logic [3:0] wd);
    logic [31:0] w;
    w = $urandom;
    w[3:0] = wd;
    if (m == 0) begin
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = we; bus.m0_addr_i = a; bus.m0_data_i = w;
    end else begin
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = we; bus.m1_addr_i = a; bus.m1_data_i = w;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) begin bus.m0_cyc_i = 0; bus.m0_stb_i = 0; end
    else begin bus.m1_cyc_i = 0; bus.m1_stb_i = 0; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_cyc"}, 32'(bus.s_cyc_o), 0);
    chk({tag, "_s_stb"}, 32'(bus.s_stb_o), 0);
    chk({tag, "_s_we"}, 32'(bus.s_we_o), 0);
    chk({tag, "_s_addr"}, bus.s_addr_o, 0);
    chk({tag, "_s_data"}, bus.s_data_o, 0);
    chk({tag, "_resp"}, 32'({bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}), 0);
    chk({tag, "_m0_data"}, bus.m0_data_o, 0);
    chk({tag, "_m1_data"}, bus.m1_data_o, 0);
  endtask

  // Serve one granted transaction of master m; its request is already up and is granted on the next edge.
  // The chip acks d samples after the strobe appears (never when d > TIMEOUT).
  task automatic serve(input int m, input logic [31:0] a, input logic we, input logic [3:0] wd,
                       input int d, input logic [3:0] rn, input logic [3:0] ecyc,
                       input logic [31:0] esaddr, input bit eerr);
    int  chip, r;
    bit  dec;
    logic [1:0] resp, other;
    dec  = (ecyc == 0);
    chip = (a >> 9) % 4;
    bus.s_data_i = {$urandom, $urandom, $urandom, $urandom};
    bus.s_data_i[32*chip +: 32] = {28'd0, rn};
    r = dec ? 1 : ((d <= TIMEOUT) ? d + 1 : TIMEOUT + 1);
    for (int k = 1; k <= r + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("idle_resp", 32'({bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}), 0);
        chk("s_cyc", 32'(bus.s_cyc_o), 32'(ecyc));
        chk("s_stb", 32'(bus.s_stb_o), 32'(ecyc));
        if (!dec) begin
          chk("s_addr", bus.s_addr_o, esaddr);
          chk("s_data", bus.s_data_o, {28'd0, wd});
          chk("s_we", 32'(bus.s_we_o), 32'(we));
        end
      end else if (k < r) begin
        chk("cyc_hold", 32'(bus.s_cyc_o), 32'(ecyc));
      end
      if (k == r && !dec) begin
        chk("cyc_drop", 32'(bus.s_cyc_o), 0);
        bus.s_ack_i = 4'd0;
      end
      if (!dec && k == d && d <= TIMEOUT) bus.s_ack_i[chip] = 1'b1;
      if (k == r + 1) begin
        if (!eerr && !we) exp_data[m] = {28'd0, rn};
        resp  = (m == 0) ? {bus.m0_ack_o, bus.m0_err_o} : {bus.m1_ack_o, bus.m1_err_o};
        other = (m == 0) ? {bus.m1_ack_o, bus.m1_err_o} : {bus.m0_ack_o, bus.m0_err_o};
        chk($sformatf("m%0d_ack_err", m), 32'(resp), eerr ? 32'd1 : 32'd2);
        chk("other_resp", 32'(other), 0);
        chk("m0_data", bus.m0_data_o, exp_data[0]);
        chk("m1_data", bus.m1_data_o, exp_data[1]);
        drop_req(m);
      end
    end
  endtask

  // One arbitration round from idle using ta/twe/twd/td/tn; model picks the order
  task automatic round(input bit r0, input bit r1);
    int first, second;
    first = (r0 && r1) ? ((last_gnt == 1) ? 0 : 1) : (r1 ? 1 : 0);
    second = 1 - first;
    if (r0) set_req(0, twe[0], ta[0], twd[0]);
    if (r1) set_req(1, twe[1], ta[1], twd[1]);
    serve(first, ta[first], twe[first], twd[first], td[first], tn[first], cyc_of(ta[first]),
          ta[first] & 32'h1FC, (cyc_of(ta[first]) == 0) || (td[first] > TIMEOUT));
    last_gnt = first;
    if (r0 && r1) begin
      serve(second, ta[second], twe[second], twd[second], td[second], tn[second], cyc_of(ta[second]),
            ta[second] & 32'h1FC, (cyc_of(ta[second]) == 0) || (td[second] > TIMEOUT));
      last_gnt = second;
    end
  endtask

  task automatic rand_txn(input int m);
    ta[m]  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h800) : ($urandom & 32'h7FF);
    twe[m] = 1'($urandom_range(0, 1));
    twd[m] = 4'($urandom);
    tn[m]  = 4'($urandom);
    td[m]  = ($urandom_range(0, 15) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 1) : $urandom_range(1, 6);
  endtask

  initial begin
    vecs[0] = '{0, 32'h0000_0414, 1'b1, 4'hA, 5,  4'h0, 4'b0100, 32'h14,  1'b0};
    vecs[1] = '{1, 32'h0000_0300, 1'b0, 4'h0, 2,  4'h7, 4'b0010, 32'h100, 1'b0};
    vecs[2] = '{0, 32'h0000_0800, 1'b0, 4'h0, 1,  4'h0, 4'b0000, 32'h0,   1'b1};
    vecs[3] = '{0, 32'h0000_01FC, 1'b0, 4'h0, 1,  4'hC, 4'b0001, 32'h1FC, 1'b0};
    vecs[4] = '{1, 32'h0000_07FF, 1'b1, 4'h5, 3,  4'h0, 4'b1000, 32'h1FC, 1'b0};
    vecs[5] = '{0, 32'h0000_0600, 1'b0, 4'h0, 31, 4'h3, 4'b1000, 32'h0,   1'b0};
    vecs[6] = '{1, 32'h0000_0204, 1'b0, 4'h0, 32, 4'h9, 4'b0010, 32'h4,   1'b1};
    vecs[7] = '{1, 32'h8000_0000, 1'b1, 4'h1, 1,  4'h0, 4'b0000, 32'h0,   1'b1};

    rst_n = 0;
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = 0; bus.m0_data_i = 0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = 0; bus.m1_data_i = 0;
    bus.s_data_i = '0; bus.s_ack_i = '0;
    exp_data[0] = 0; exp_data[1] = 0; last_gnt = 1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;

    // Simultaneous requests from reset alternate m0, m1, m0, m1 ...
    for (int i = 0; i < 3; i++) begin
      rand_txn(0); rand_txn(1);
      ta[0] = ta[0] & 32'h7FF; ta[1] = ta[1] & 32'h7FF; td[0] = 2; td[1] = 3;
      round(1, 1);
    end

    // Directed vectors
    foreach (vecs[i]) begin
      set_req(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wd);
      serve(vecs[i].m, vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].d, vecs[i].rn,
            vecs[i].ecyc, vecs[i].esaddr, vecs[i].eerr);
      last_gnt = vecs[i].m;
    end

    // Tie right after an m0 win must go to m1
    rand_txn(0); ta[0] = 32'h0000_0010; td[0] = 1; round(1, 0);
    rand_txn(0); rand_txn(1); round(1, 1);

    // Master abort: m0 drops cyc mid-wait, slave still completes, no ack, data kept
    bus.s_data_i[31:0] = 32'h9;
    set_req(0, 1'b0, 32'h0000_0000, 4'h0);
    @(negedge clk); chk("abort_cyc", 32'(bus.s_cyc_o), 32'h1);
    drop_req(0);
    @(negedge clk); chk("abort_hold", 32'(bus.s_cyc_o), 32'h1);
    bus.s_ack_i[0] = 1'b1;
    @(negedge clk); chk("abort_drop", 32'(bus.s_cyc_o), 0);
    bus.s_ack_i = '0;
    @(negedge clk); chk("abort_no_ack", 32'({bus.m0_ack_o, bus.m0_err_o}), 0);
    chk("abort_m0_data", bus.m0_data_o, exp_data[0]);
    last_gnt = 0;

    // Randomized rounds against the model
    for (int i = 0; i < 24; i++) begin
      int mask;
      mask = $urandom_range(1, 3);
      rand_txn(0); rand_txn(1);
      round(mask[0], mask[1]);
    end

    // Give m1 a nonzero read value, then reset during WAIT
    rand_txn(1); ta[1] = 32'h0000_0108; twe[1] = 0; tn[1] = 4'hE; td[1] = 1; round(0, 1);
    set_req(1, 1'b0, 32'h0000_0204, 4'h0);
    @(negedge clk); chk("pre_rst_cyc", 32'(bus.s_cyc_o), 32'h2);
    @(negedge clk); rst_n = 0;
    @(negedge clk); chk_all_zero("mid_rst");
    drop_req(1); bus.s_ack_i = '0;
    exp_data[0] = 0; exp_data[1] = 0; last_gnt = 1;
    rst_n = 1;

    rand_txn(1); ta[1] = 32'h0000_0604; twe[1] = 0; td[1] = 2; round(0, 1);
    rand_txn(0); rand_txn(1); round(1, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
